// File: rtl/sbox_pkg.sv
// Shared types, constants and affine helpers for the power-chain AES S-box.
package sbox_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] AFFINE_CONST     = 8'h63;
    localparam logic [7:0] INV_AFFINE_CONST = 8'h05;
    localparam logic [7:0] GF_POLY          = 8'h1B;
    localparam int         STEPS            = 7;
    localparam logic [2:0] STEP_LAST        = 3'(STEPS - 1);

    // Multiply by x modulo the field polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // Forward affine: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 63.
    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ AFFINE_CONST;
    endfunction

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 05.
    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]}
             ^ INV_AFFINE_CONST;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier (shift-and-add over x^8+x^4+x^3+x+1).
module gf256_mul
    import sbox_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] product
);

    logic [7:0] w_shift [0:7];
    logic [7:0] w_sum   [0:8];

    assign w_shift[0] = a;
    assign w_sum[0]   = 8'h00;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_shift
            assign w_shift[gi+1] = xtime(w_shift[gi]);
        end
        for (gi = 0; gi < 8; gi++) begin : g_sum
            assign w_sum[gi+1] = w_sum[gi] ^ (b[gi] ? w_shift[gi] : 8'h00);
        end
    endgenerate

    assign product = w_sum[8];

endmodule

// File: rtl/sbox_inv_pow.sv
// AES S-box / inverse S-box via x^254 square-and-multiply, no lookup table.
// Define SBOX_POW_UNROLL2_EN to run two square-multiply steps per CALC cycle.
module sbox_inv_pow
    import sbox_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       encrypt,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] byte_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] byte_out,
    output logic       busy
);

    state_t     r_state;
    logic [7:0] r_p;
    logic [7:0] r_acc;
    logic [7:0] r_byte_out;
    logic [2:0] r_step;
    logic       r_mode_q;
    logic       r_fin;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_busy;

    logic [7:0] w_p_sq;
    logic [7:0] w_acc1;

    gf256_mul u_sq  (.a(r_p),   .b(r_p),    .product(w_p_sq));
    gf256_mul u_mul (.a(r_acc), .b(w_p_sq), .product(w_acc1));

`ifdef SBOX_POW_UNROLL2_EN
    logic [7:0] w_p_sq2;
    logic [7:0] w_acc2;

    gf256_mul u_sq2  (.a(w_p_sq), .b(w_p_sq),  .product(w_p_sq2));
    gf256_mul u_mul2 (.a(w_acc1), .b(w_p_sq2), .product(w_acc2));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_p         <= 8'h00;
            r_acc       <= 8'h01;
            r_byte_out  <= 8'h00;
            r_step      <= 3'd0;
            r_mode_q    <= 1'b1;
            r_fin       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mode_q   <= encrypt;
                        r_p        <= encrypt ? byte_in : inv_affine(byte_in);
                        r_acc      <= 8'h01;
                        r_step     <= 3'd0;
                        r_fin      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    // r_fin marks that all squarings are in r_acc; this cycle only registers the result.
                    if (r_fin) begin
                        r_byte_out  <= r_mode_q ? affine(r_acc) : r_acc;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
`ifdef SBOX_POW_UNROLL2_EN
                        if (r_step == STEP_LAST) begin
                            r_p   <= w_p_sq;
                            r_acc <= w_acc1;
                            r_fin <= 1'b1;
                        end else begin
                            r_p    <= w_p_sq2;
                            r_acc  <= w_acc2;
                            r_step <= r_step + 3'd2;
                        end
`else
                        r_p   <= w_p_sq;
                        r_acc <= w_acc1;
                        if (r_step == STEP_LAST) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_step <= r_step + 3'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign byte_out  = r_byte_out;
    assign busy      = r_busy;

endmodule

// File: doc/sbox_inv_pow.md
SBOX_INV_POW -- requirements
Module: sbox_inv_pow

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 encrypt  input  1  1 = forward S-box, 0 = inverse S-box; sampled only on input accept.
REQ-005 in_valid  input  1  byte_in is valid.
REQ-006 in_ready  output  1  block can accept a byte.
REQ-007 byte_in  input  8  input byte.
REQ-008 out_valid  output  1  byte_out is valid.
REQ-009 out_ready  input  1  consumer accepts byte_out.
REQ-010 byte_out  output  8  S-box or inverse S-box result.
REQ-011 busy  output  1  high in CALC and DONE.

Function
REQ-012 The block SHALL compute the multiplicative inverse in GF(2^8) as x^254, with no lookup table.
- Field polynomial: x^8+x^4+x^3+x+1 (reduction constant 8'h1B).
- x^254 = product of x^(2^i) for i=1..7.
REQ-013 The state machine SHALL have three states: IDLE, CALC, DONE.
REQ-014 IDLE:
- in_ready=1.
- On in_valid&&in_ready, the block latches encrypt into mode_q.
- Encrypt: the block loads p=byte_in.
- Decrypt: the block loads p=inverse_affine(byte_in), with constant 8'h05.
- The block sets acc=8'h01 and step=0, and goes to CALC.
REQ-015 CALC: each cycle, p<=p*p, then acc<=acc*(p*p), then step<=step+1; after step 6 (7 steps total) the block goes to DONE.
REQ-016 On entry to DONE, the block SHALL register byte_out:
- mode_q=1: affine(acc), with constant 8'h63.
- mode_q=0: acc.
- out_valid=1.
REQ-017 Latency SHALL be exactly 8 cycles from the accept edge to the first cycle out_valid=1.
REQ-018 DONE SHALL hold byte_out and out_valid stable until out_ready=1, then go to IDLE.
REQ-019 in_ready SHALL be 0 in CALC and DONE; the block ignores in_valid there and makes no second accept.
REQ-020 A new byte SHALL NOT be accepted in the same cycle as an out_ready handshake; the earliest next accept is the following cycle.
REQ-021 Input 8'h00 SHALL need no special casing: 0^254=0, giving S(00)=63 and InvS(63)=00.
REQ-022 Changes on encrypt after accept SHALL have no effect on the result in flight.
REQ-023 step SHALL be 3 bits and SHALL never exceed 6.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL set:
- state=IDLE, in_ready=1 (after reset), out_valid=0, busy=0;
- byte_out=8'h00, acc=8'h01, p=8'h00, step=0, mode_q=1.
REQ-025 Reset in CALC or DONE SHALL discard the operation in flight; the block SHALL produce no out_valid pulse for it.
REQ-026 Reset SHALL take priority over a simultaneous in_valid or out_ready.

Configuration
REQ-027 Macro SBOX_POW_UNROLL2_EN, when defined, SHALL make CALC perform two square-multiply steps per cycle:
- CALC lasts 4 cycles; the last cycle does one step.
- Latency is 5 cycles.
REQ-028 Without SBOX_POW_UNROLL2_EN, the block SHALL perform one step per cycle with the latency of REQ-017.
REQ-029 Results SHALL be identical in both configurations.

Structure
REQ-030 Shared package sbox_pkg SHALL contain:
- state typedef (IDLE, CALC, DONE);
- AFFINE_CONST=8'h63, INV_AFFINE_CONST=8'h05, GF_POLY=8'h1B;
- STEPS=7.
REQ-031 GF(2^8) multiplication SHALL be one combinational sub-module, gf256_mul (a, b -> product).
- Instantiated twice per step (square, multiply); four times with SBOX_POW_UNROLL2_EN.
REQ-032 Affine and inverse-affine SHALL be functions in sbox_pkg.

Verification
REQ-033 encrypt=1, byte_in=53 -> after 8 cycles byte_out=ED, out_valid=1; hold out_ready=0 for 5 cycles -> value stable.
REQ-034 encrypt=0, byte_in=ED -> byte_out=53; encrypt=0, byte_in=7C -> byte_out=01; encrypt=0, byte_in=63 -> byte_out=00.
REQ-035 Sweep 00..FF, both modes -> InvS(S(x))=x for all 256 values; S(00)=63, S(01)=7C.
REQ-036 Assert reset in cycle 4 of CALC -> out_valid never rises; next byte 01, encrypt=1 -> 7C.
REQ-037 Hold in_valid high through CALC/DONE with changing byte_in and encrypt -> exactly one result, from the first accepted byte.
REQ-038 Rerun REQ-033..REQ-037 with SBOX_POW_UNROLL2_EN -> same values, latency 5.
